// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory / MMIO block: address map, register
// offsets, STATUS bit positions and reset values.
package dmem_mmio_pkg;

  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;

  localparam logic [3:0] OFF_OUTPORT = 4'h0;
  localparam logic [3:0] OFF_COUNT   = 4'h4;
  localparam logic [3:0] OFF_CMP     = 4'h8;
  localparam logic [3:0] OFF_STATUS  = 4'hC;

  localparam int STATUS_MATCH_BIT  = 0;
  localparam int STATUS_ENABLE_BIT = 1;

  localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_OUTPORT,
    SEL_COUNT,
    SEL_CMP,
    SEL_STATUS
  } sel_e;

  // True when the address falls in the 16-byte MMIO window.
  function automatic logic is_mmio(input logic [31:0] addr);
    return addr[31:4] == MMIO_BASE[31:4];
  endfunction

endpackage

// File: rtl/dmem_timer.sv
// Compare/match timer: COUNT, CMP and STATUS registers with a level irq that
// mirrors STATUS.MATCH.
module dmem_timer
  import dmem_mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_we_count,
  input  logic        i_we_cmp,
  input  logic        i_we_status,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_cmp,
  output logic [31:0] o_status,
  output logic        o_irq
);

  logic [31:0] r_count;
  logic [31:0] r_cmp;
  logic        r_match;
  logic        r_enable;

  logic        w_hit;
  logic [31:0] w_count_nxt;
  logic        w_match_nxt;

  // A software COUNT write suppresses the reload and the match it would cause.
  assign w_hit = r_enable && (r_count == r_cmp) && !i_we_count;

  always_comb begin
    w_count_nxt = r_count;
    if (i_we_count)
      w_count_nxt = i_wdata;
    else if (r_enable)
      w_count_nxt = w_hit ? 32'h0 : r_count + 32'h1;
  end

  // Hardware set wins over a simultaneous write-1-clear.
  always_comb begin
    w_match_nxt = r_match;
    if (w_hit)
      w_match_nxt = 1'b1;
    else if (i_we_status && i_wdata[STATUS_MATCH_BIT])
      w_match_nxt = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= 32'h0;
      r_cmp    <= CMP_RESET;
      r_match  <= 1'b0;
      r_enable <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_match <= w_match_nxt;
      if (i_we_cmp)
        r_cmp <= i_wdata;
      if (i_we_status)
        r_enable <= i_wdata[STATUS_ENABLE_BIT];
    end
  end

  always_comb begin
    o_status                    = 32'h0;
    o_status[STATUS_MATCH_BIT]  = r_match;
    o_status[STATUS_ENABLE_BIT] = r_enable;
  end

  assign o_count = r_count;
  assign o_cmp   = r_cmp;
  assign o_irq   = r_match;

endmodule

// File: rtl/dmem_mmio.sv
// Data RAM plus MMIO block (OUTPORT and optional timer) for a single-cycle core.
// Define DMEM_MMIO_TIMER_EN to include the COUNT/CMP/STATUS timer and irq.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int RAM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] outport,
  output logic        irq
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]   r_ram [RAM_WORDS];
  logic [31:0]   r_outport;

  sel_e          w_sel;
  logic [AW-1:0] w_idx;
  logic          w_wr;
  logic          w_unused_lsbs;

  assign w_idx         = aluout[AW+1:2];
  assign w_wr          = memwrite && !reset;
  assign w_unused_lsbs = &{1'b0, aluout[1:0]};

  always_comb begin
    w_sel = SEL_NONE;
    if (aluout[31:AW+2] == RAM_BASE[31:AW+2]) begin
      w_sel = SEL_RAM;
    end else if (is_mmio(aluout)) begin
      case ({aluout[3:2], 2'b00})
        OFF_OUTPORT: w_sel = SEL_OUTPORT;
`ifdef DMEM_MMIO_TIMER_EN
        OFF_COUNT:   w_sel = SEL_COUNT;
        OFF_CMP:     w_sel = SEL_CMP;
        OFF_STATUS:  w_sel = SEL_STATUS;
`endif
        default:     w_sel = SEL_NONE;
      endcase
    end
  end

  // NOTE: the RAM has no reset branch so it maps onto block RAM; only the
  // write is gated by reset.
  always_ff @(posedge clk) begin
    if (w_wr && w_sel == SEL_RAM)
      r_ram[w_idx] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_outport <= 32'h0;
    else if (w_wr && w_sel == SEL_OUTPORT)
      r_outport <= writedata;
  end

  assign outport = r_outport;

`ifdef DMEM_MMIO_TIMER_EN
  logic [31:0] w_count;
  logic [31:0] w_cmp;
  logic [31:0] w_status;

  dmem_timer u_timer (
    .clk         (clk),
    .reset       (reset),
    .i_we_count  (w_wr && w_sel == SEL_COUNT),
    .i_we_cmp    (w_wr && w_sel == SEL_CMP),
    .i_we_status (w_wr && w_sel == SEL_STATUS),
    .i_wdata     (writedata),
    .o_count     (w_count),
    .o_cmp       (w_cmp),
    .o_status    (w_status),
    .o_irq       (irq)
  );
`else
  assign irq = 1'b0;
`endif

  // NOTE: every combinational output gets a default first so no latch forms.
  always_comb begin
    readdata = 32'h0;
    case (w_sel)
      SEL_RAM:     readdata = r_ram[w_idx];
      SEL_OUTPORT: readdata = r_outport;
`ifdef DMEM_MMIO_TIMER_EN
      SEL_COUNT:   readdata = w_count;
      SEL_CMP:     readdata = w_cmp;
      SEL_STATUS:  readdata = w_status;
`endif
      default:     readdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: vector table for RAM/OUTPORT/decode plus
// hand sequences for reset and the timer (or its absence).
module tb_dmem_mmio;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] outport;
  logic        irq;

  int checks = 0;
  int errors = 0;

  dmem_mmio #(.RAM_WORDS(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .aluout    (aluout),
    .writedata (writedata),
    .readdata  (readdata),
    .outport   (outport),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [31:0] exp_out;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    aluout    = addr;
    writedata = data;
    memwrite  = 1'b1;
    step();
    memwrite  = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    aluout = addr;
    #1;
    check(name, readdata, exp);
  endtask

  initial begin
    reset = 1'b1; memwrite = 1'b0; aluout = 32'h0; writedata = 32'h0;
    repeat (2) step();
    reset = 1'b0;

    //            we    addr           wdata          chk   exp_rd         exp_out
    vecs.push_back('{1'b0, 32'hFFFF_0000, 32'h0,         1'b1, 32'h0,         32'h0,  "rst_outport"});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'h0,         32'h0,  "wr_ram0"});
    vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         32'h0,  "wr_ram4"});
    vecs.push_back('{1'b1, 32'h0000_00FC, 32'h0BAD_F00D, 1'b0, 32'h0,         32'h0,  "wr_ram_top"});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 32'h0,  "rd_ram4"});
    vecs.push_back('{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF, 32'h0,  "rd_ram4_lsb"});
    vecs.push_back('{1'b1, 32'h0000_0010, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF, 32'h0,  "same_cycle_old"});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'h1234_5678, 32'h0,  "rd_ram4_new"});
    vecs.push_back('{1'b0, 32'h0000_00FC, 32'h0,         1'b1, 32'h0BAD_F00D, 32'h0,  "rd_ram_top"});
    vecs.push_back('{1'b1, 32'hFFFF_0000, 32'h0000_00A5, 1'b1, 32'h0,         32'h0,  "wr_outport"});
    vecs.push_back('{1'b0, 32'hFFFF_0000, 32'h0,         1'b1, 32'h0000_00A5, 32'hA5, "rd_outport"});
    vecs.push_back('{1'b0, 32'h0000_4000, 32'h0,         1'b1, 32'h0,         32'hA5, "rd_unmap_lo"});
    vecs.push_back('{1'b0, 32'hFFFF_0010, 32'h0,         1'b1, 32'h0,         32'hA5, "rd_unmap_hi"});
    vecs.push_back('{1'b1, 32'h0000_4000, 32'hCAFE_F00D, 1'b1, 32'h0,         32'hA5, "wr_unmap_lo"});
    vecs.push_back('{1'b1, 32'hFFFF_0010, 32'h0000_0077, 1'b1, 32'h0,         32'hA5, "wr_unmap_hi"});
    vecs.push_back('{1'b1, 32'h0000_0100, 32'h5555_5555, 1'b1, 32'h0,         32'hA5, "wr_past_ram"});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h1111_1111, 32'hA5, "ram0_intact"});
    vecs.push_back('{1'b0, 32'h0000_00FC, 32'h0,         1'b1, 32'h0BAD_F00D, 32'hA5, "ram_top_intact"});
    vecs.push_back('{1'b0, 32'hFFFF_0003, 32'h0,         1'b1, 32'h0000_00A5, 32'hA5, "rd_outport_lsb"});

    foreach (vecs[i]) begin
      aluout    = vecs[i].addr;
      writedata = vecs[i].wdata;
      memwrite  = vecs[i].we;
      #1;
      if (vecs[i].chk_rd)
        check({vecs[i].name, "_rd"}, readdata, vecs[i].exp_rd);
      check({vecs[i].name, "_out"}, outport, vecs[i].exp_out);
      step();
      memwrite = 1'b0;
    end
    check("irq_idle", {31'h0, irq}, 32'h0);

    // Stores coincident with reset are discarded; RAM keeps its contents.
    reset = 1'b1; memwrite = 1'b1;
    aluout = 32'hFFFF_0000; writedata = 32'h0000_0055;
    step();
    aluout = 32'h0000_0010; writedata = 32'h0000_0099;
    step();
    reset = 1'b0; memwrite = 1'b0;
    check("reset_outport", outport, 32'h0);
    rd_check("reset_ram_kept", 32'h0000_0010, 32'h1234_5678);
    rd_check("reset_rd_outport", 32'hFFFF_0000, 32'h0);

`ifdef DMEM_MMIO_TIMER_EN
    rd_check("rst_count", 32'hFFFF_0004, 32'h0);
    rd_check("rst_cmp", 32'hFFFF_0008, 32'hFFFF_FFFF);
    rd_check("rst_status", 32'hFFFF_000C, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);

    wr(32'hFFFF_0008, 32'h3);
    wr(32'hFFFF_000C, 32'h2);
    rd_check("cnt_0", 32'hFFFF_0004, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("cnt_%0d", k), readdata, k);
      check($sformatf("irq_low_%0d", k), {31'h0, irq}, 32'h0);
    end
    step();
    check("cnt_wrap", readdata, 32'h0);
    check("irq_rise", {31'h0, irq}, 32'h1);
    rd_check("status_match", 32'hFFFF_000C, 32'h3);

    wr(32'hFFFF_000C, 32'h3);
    check("w1c_irq", {31'h0, irq}, 32'h0);
    rd_check("cnt_after_w1c", 32'hFFFF_0004, 32'h1);
    step();
    step();
    check("cnt_at_cmp", readdata, 32'h3);

    wr(32'hFFFF_0004, 32'h100);
    rd_check("cnt_write_prio", 32'hFFFF_0004, 32'h100);
    check("cnt_write_no_match", {31'h0, irq}, 32'h0);

    wr(32'hFFFF_0008, 32'h101);
    rd_check("cnt_eq_cmp", 32'hFFFF_0004, 32'h101);
    wr(32'hFFFF_000C, 32'h3);
    check("set_beats_w1c", {31'h0, irq}, 32'h1);
    rd_check("cnt_reload", 32'hFFFF_0004, 32'h0);

    wr(32'hFFFF_000C, 32'h0);
    rd_check("cnt_freeze_a", 32'hFFFF_0004, 32'h1);
    repeat (3) step();
    check("cnt_freeze_b", readdata, 32'h1);
    check("match_hold", {31'h0, irq}, 32'h1);
`else
    wr(32'hFFFF_000C, 32'h2);
    wr(32'hFFFF_0004, 32'h5);
    wr(32'hFFFF_0008, 32'h7);
    repeat (10) step();
    rd_check("notmr_count", 32'hFFFF_0004, 32'h0);
    rd_check("notmr_cmp", 32'hFFFF_0008, 32'h0);
    rd_check("notmr_status", 32'hFFFF_000C, 32'h0);
    check("notmr_irq", {31'h0, irq}, 32'h0);
    check("notmr_outport", outport, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 Parameter: RAM_WORDS, 64, number of 32-bit data RAM words (power of two, 16..1024).
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: memwrite  input  1  store strobe from core, sampled at rising edge.
REQ-005 Port: aluout  input  32  byte address from core (word access; addr[1:0] ignored).
REQ-006 Port: writedata  input  32  store data from core.
REQ-007 Port: readdata  output  32  load data to core, combinational from aluout.
REQ-008 Port: outport  output  32  memory-mapped output register value.
REQ-009 Port: irq  output  1  timer match flag, level, equals STATUS.MATCH.

Function
REQ-010 Address map SHALL be: RAM at 0x0000_0000 .. 4*RAM_WORDS-1; MMIO block at 0xFFFF_0000 .. 0xFFFF_000F; all else unmapped.
REQ-011 MMIO registers SHALL be: +0x0 OUTPORT (rw), +0x4 COUNT (rw), +0x8 CMP (rw), +0xC STATUS (bit0 MATCH r/w1c, bit1 ENABLE rw, others read 0).
REQ-012 Reads SHALL be combinational, zero-latency: readdata reflects aluout and current register/RAM state in the same cycle.
REQ-013 Writes SHALL take effect at the rising edge where memwrite=1; a read of the same address in that cycle returns the old value.
REQ-014 Unmapped reads SHALL return 0x0000_0000; unmapped writes SHALL be ignored with no side effects.
REQ-015 RAM index SHALL be aluout[log2(RAM_WORDS)+1:2].
REQ-016 When ENABLE=1 and no COUNT write, COUNT SHALL increment by 1 per cycle.
REQ-017 When ENABLE=1 and COUNT==CMP, next COUNT SHALL be 0 and MATCH SHALL set; 32-bit wrap 0xFFFF_FFFF->0 without match when CMP differs.
REQ-018 A COUNT write SHALL take priority over increment and match-reload in the same cycle.
REQ-019 Match set SHALL take priority over a simultaneous write-1-clear of MATCH.
REQ-020 ENABLE=0 SHALL freeze COUNT; MATCH holds its value.
REQ-021 irq SHALL equal MATCH with no added latency.

Reset
REQ-022 On reset: OUTPORT=0, COUNT=0, CMP=0xFFFF_FFFF, STATUS=0, irq=0, outport=0.
REQ-023 RAM contents SHALL NOT be reset; a store coincident with reset SHALL be discarded for registers and RAM.
REQ-024 Reset SHALL override any in-progress counting in the same edge.

Configuration
REQ-025 Macro DMEM_MMIO_TIMER_EN: defined -> COUNT/CMP/STATUS and irq behave as above.
REQ-026 Without DMEM_MMIO_TIMER_EN: offsets +0x4..+0xC behave as unmapped (read 0, writes ignored), irq tied 0; RAM and OUTPORT unchanged.

Structure
REQ-027 Shared package SHALL hold RAM base, MMIO base, register offsets, STATUS bit positions and CMP reset value.
REQ-028 Timer (COUNT, CMP, STATUS, irq) SHALL be sub-module dmem_timer; RAM, decode and OUTPORT stay in dmem_mmio.

Verification
REQ-029 Store 0xDEAD_BEEF to 0x0000_0010, load 0x0000_0010 next cycle -> readdata=0xDEAD_BEEF; load 0x0000_0013 -> same value.
REQ-030 Store 0x0000_00A5 to 0xFFFF_0000 -> outport=0x0000_00A5 after that edge; reset -> outport=0.
REQ-031 CMP=3, STATUS=0x2 -> COUNT reads 1,2,3,0; irq rises the cycle COUNT returns to 0; write STATUS=0x3 -> irq=0 next cycle.
REQ-032 COUNT write 0x100 in a cycle where COUNT==CMP -> COUNT=0x100, MATCH unchanged; W1C on a match cycle -> MATCH stays 1.
REQ-033 Load 0x0000_4000 and 0xFFFF_0010 -> readdata=0; store there -> no RAM/register change.
REQ-034 Build without DMEM_MMIO_TIMER_EN: store 0x2 to 0xFFFF_000C, wait 10 cycles -> reads of +0x4/+0xC return 0, irq=0.
